module_alu_shifter_seq: RTL and testbench

- Multi-cycle, parametrised shifter unit for the ALU datapath.
- Successor of the single-cycle fill-capable left shifter. Adds:
  - configurable width and bits-per-cycle
  - left/right direction
  - logical/fill, arithmetic and rotate modes
  - a valid/ready start handshake and a done pulse
- Sits beside the other ALU operation modules; the ALU result mux samples result_o/carry_o on done_o.

---
 rtl/module_alu_shifter_seq_pkg.sv | 24 ++
 rtl/module_alu_shifter_seq_if.sv | 27 ++
 rtl/module_shift_step.sv | 46 ++++
 rtl/module_alu_shifter_seq.sv | 118 +++++++++++
 tb/tb_module_alu_shifter_seq.sv | 324 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/module_alu_shifter_seq_pkg.sv
// Shared types for the multi-cycle shifter: operation modes, FSM states, direction codes.
package pkg_bits;

    typedef enum logic [1:0] {
        MODE_FILL  = 2'b00,
        MODE_ARITH = 2'b01,
        MODE_ROT   = 2'b10
    } shift_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DONE
    } shift_state_e;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    // The reserved encoding 2'b11 behaves exactly like fill.
    function automatic shift_mode_e decode_mode(input logic [1:0] m);
        return (m == 2'b11) ? MODE_FILL : shift_mode_e'(m);
    endfunction

endpackage

// File: rtl/module_alu_shifter_seq_if.sv
// Request/result bundle between the ALU control and the shifter; master drives the request.
interface module_alu_shifter_seq_if #(
    parameter int WIDTH   = 8,
    parameter int SHAMT_W = $clog2(WIDTH) + 1
);
    logic               start_i;
    logic [WIDTH-1:0]   a_i;
    logic [SHAMT_W-1:0] b_i;
    logic               dir_i;
    logic [1:0]         mode_i;
    logic               fill_i;
    logic               ready_o;
    logic               done_o;
    logic [WIDTH-1:0]   result_o;
    logic               carry_o;
    logic               zero_o;

    modport master (
        output start_i, a_i, b_i, dir_i, mode_i, fill_i,
        input  ready_o, done_o, result_o, carry_o, zero_o
    );

    modport slave (
        input  start_i, a_i, b_i, dir_i, mode_i, fill_i,
        output ready_o, done_o, result_o, carry_o, zero_o
    );
endinterface

// File: rtl/module_shift_step.sv
// Combinational step: shifts a word by k (0..STEP) single-bit positions and reports the last bit out.
module module_shift_step
    import pkg_bits::*;
#(
    parameter int WIDTH = 8,
    parameter int STEP  = 1,
    parameter int KW    = $clog2(WIDTH) + 1
) (
    input  logic [WIDTH-1:0] word_i,
    input  logic [KW-1:0]    k_i,
    input  logic             dir_i,
    input  shift_mode_e      mode_i,
    input  logic             fill_i,
    output logic [WIDTH-1:0] word_o,
    output logic             out_bit_o
);

    logic [WIDTH-1:0] w;
    logic             ob;
    logic             ins;

    always_comb begin
        w   = word_i;
        ob  = 1'b0;
        ins = 1'b0;
        // Unrolled chain of single-bit moves; only the first k stages are active.
        for (int i = 0; i < STEP; i++) begin
            if (KW'(i) < k_i) begin
                if (dir_i == DIR_LEFT) begin
                    ob  = w[WIDTH-1];
                    ins = (mode_i == MODE_ROT)   ? w[WIDTH-1] :
                          (mode_i == MODE_ARITH) ? 1'b0 : fill_i;
                    w   = {w[WIDTH-2:0], ins};
                end else begin
                    ob  = w[0];
                    ins = (mode_i == MODE_ROT)   ? w[0] :
                          (mode_i == MODE_ARITH) ? w[WIDTH-1] : fill_i;
                    w   = {ins, w[WIDTH-1:1]};
                end
            end
        end
        word_o    = w;
        out_bit_o = ob;
    end

endmodule

// File: rtl/module_alu_shifter_seq.sv
// Multi-cycle shifter: IDLE accepts a request, SHIFT moves up to STEP bits per clock, DONE pulses done_o.
// Result, carry and zero are registered on entry to DONE and held until the next accept.
module module_alu_shifter_seq
    import pkg_bits::*;
#(
    parameter int WIDTH   = 8,
    parameter int STEP    = 1,
    parameter int SHAMT_W = $clog2(WIDTH) + 1
) (
    input  logic clk_i,
    input  logic rst_n_i,
    module_alu_shifter_seq_if.slave sh_if
);

    shift_state_e       state_q, state_d;
    logic [WIDTH-1:0]   work_q, work_d;
    logic [SHAMT_W-1:0] rem_q, rem_d;
    logic               dir_q, dir_d;
    shift_mode_e        mode_q, mode_d;
    logic               fill_q, fill_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               carry_q, carry_d;
    logic               zero_q, zero_d;

    logic [SHAMT_W-1:0] k;
    logic [WIDTH-1:0]   step_word;
    logic               step_out;

    assign k = (rem_q > SHAMT_W'(STEP)) ? SHAMT_W'(STEP) : rem_q;

    module_shift_step #(
        .WIDTH (WIDTH),
        .STEP  (STEP),
        .KW    (SHAMT_W)
    ) u_step (
        .word_i    (work_q),
        .k_i       (k),
        .dir_i     (dir_q),
        .mode_i    (mode_q),
        .fill_i    (fill_q),
        .word_o    (step_word),
        .out_bit_o (step_out)
    );

    always_comb begin
        state_d  = state_q;
        work_d   = work_q;
        rem_d    = rem_q;
        dir_d    = dir_q;
        mode_d   = mode_q;
        fill_d   = fill_q;
        result_d = result_q;
        carry_d  = carry_q;
        zero_d   = zero_q;
        case (state_q)
            ST_IDLE: begin
                if (sh_if.start_i) begin
                    work_d = sh_if.a_i;
                    rem_d  = sh_if.b_i;
                    dir_d  = sh_if.dir_i;
                    mode_d = decode_mode(sh_if.mode_i);
                    fill_d = sh_if.fill_i;
                    if (sh_if.b_i == '0) begin
                        state_d  = ST_DONE;
                        result_d = sh_if.a_i;
                        carry_d  = 1'b0;
                        zero_d   = (sh_if.a_i == '0);
                    end else begin
                        state_d = ST_SHIFT;
                    end
                end
            end
            ST_SHIFT: begin
                work_d = step_word;
                rem_d  = rem_q - k;
                if (rem_d == '0) begin
                    state_d  = ST_DONE;
                    result_d = step_word;
                    carry_d  = step_out;
                    zero_d   = (step_word == '0);
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q  <= ST_IDLE;
            work_q   <= '0;
            rem_q    <= '0;
            dir_q    <= DIR_LEFT;
            mode_q   <= MODE_FILL;
            fill_q   <= 1'b0;
            result_q <= '0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            work_q   <= work_d;
            rem_q    <= rem_d;
            dir_q    <= dir_d;
            mode_q   <= mode_d;
            fill_q   <= fill_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            zero_q   <= zero_d;
        end
    end

    assign sh_if.ready_o  = (state_q == ST_IDLE);
    assign sh_if.done_o   = (state_q == ST_DONE);
    assign sh_if.result_o = result_q;
    assign sh_if.carry_o  = carry_q;
    assign sh_if.zero_o   = zero_q;

endmodule

// File: tb/tb_module_alu_shifter_seq.sv
// Bench for the multi-cycle shifter: one STEP=1 and one STEP=2 instance, directed and random requests.
module tb_module_alu_shifter_seq;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] a_r = '0;
    logic [3:0] b_r = '0;
    logic       dir_r = 1'b0;
    logic [1:0] mode_r = '0;
    logic       fill_r = 1'b0;
    logic       start1 = 1'b0;
    logic       start2 = 1'b0;

    int checks = 0;
    int errors = 0;

    module_alu_shifter_seq_if #(.WIDTH(8)) if1 ();
    module_alu_shifter_seq_if #(.WIDTH(8)) if2 ();

    assign if1.start_i = start1;
    assign if1.a_i     = a_r;
    assign if1.b_i     = b_r;
    assign if1.dir_i   = dir_r;
    assign if1.mode_i  = mode_r;
    assign if1.fill_i  = fill_r;
    assign if2.start_i = start2;
    assign if2.a_i     = a_r;
    assign if2.b_i     = b_r;
    assign if2.dir_i   = dir_r;
    assign if2.mode_i  = mode_r;
    assign if2.fill_i  = fill_r;

    module_alu_shifter_seq #(.WIDTH(8), .STEP(1)) u_dut1 (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .sh_if   (if1.slave)
    );

    module_alu_shifter_seq #(.WIDTH(8), .STEP(2)) u_dut2 (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .sh_if   (if2.slave)
    );

    // Reference: one shift by b computed directly, rotate reduced modulo width.
    function automatic logic [8:0] ref_shift(input logic [7:0] a, input logic [3:0] b,
                                             input logic dir, input logic [1:0] mode,
                                             input logic fill);
        logic [7:0]  r;
        logic        c;
        logic        ins;
        logic [15:0] dbl;
        int          bi;
        int          n;
        bi  = int'(b);
        ins = fill;
        if (mode == 2'b01) ins = dir ? a[7] : 1'b0;
        if (bi == 0) begin
            r = a;
            c = 1'b0;
        end else if (mode == 2'b10) begin
            n   = bi % 8;
            dbl = {a, a};
            r   = dir ? dbl[n +: 8] : dbl[(8 - n) +: 8];
            c   = dir ? r[7] : r[0];
        end else if (bi >= 8) begin
            r = {8{ins}};
            c = (bi == 8) ? (dir ? a[7] : a[0]) : ins;
        end else if (!dir) begin
            r = (a << bi) | ({8{ins}} & ~(8'hFF << bi));
            c = a[8 - bi];
        end else begin
            r = (a >> bi) | ({8{ins}} & ~(8'hFF >> bi));
            c = a[bi - 1];
        end
        return {c, r};
    endfunction

    function automatic int ref_lat(input logic [3:0] b, input int step);
        return (int'(b) + step - 1) / step + 1;
    endfunction

    function automatic logic rdy_of(input int sel);
        return (sel == 1) ? if1.ready_o : if2.ready_o;
    endfunction

    function automatic logic done_of(input int sel);
        return (sel == 1) ? if1.done_o : if2.done_o;
    endfunction

    // Issues one request and waits (bounded) for done_o; lat counts the edge at which done is sampled.
    task automatic do_op(input int sel, input logic [7:0] a, input logic [3:0] b, input logic dir,
                         input logic [1:0] mode, input logic fill,
                         output logic [7:0] res, output logic c, output logic z,
                         output int lat, output bit ok);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!rdy_of(sel) && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        a_r = a; b_r = b; dir_r = dir; mode_r = mode; fill_r = fill;
        if (sel == 1) start1 = 1'b1; else start2 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        start2 = 1'b0;
        lat = 1;
        ok  = 1'b0;
        while (!ok && lat < 100) begin
            if (done_of(sel)) ok = 1'b1;
            else begin
                @(posedge clk); #1;
                lat++;
            end
        end
        res = (sel == 1) ? if1.result_o : if2.result_o;
        c   = (sel == 1) ? if1.carry_o  : if2.carry_o;
        z   = (sel == 1) ? if1.zero_o   : if2.zero_o;
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        checks++;
        if ({if1.ready_o, if1.done_o, if1.result_o, if1.carry_o, if1.zero_o} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_dut1: rdy=%b done=%b res=%h c=%b z=%b, want 1 0 00 0 1",
                     if1.ready_o, if1.done_o, if1.result_o, if1.carry_o, if1.zero_o);
        end
        checks++;
        if ({if2.ready_o, if2.done_o, if2.result_o, if2.carry_o, if2.zero_o} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_dut2: rdy=%b done=%b res=%h c=%b z=%b, want 1 0 00 0 1",
                     if2.ready_o, if2.done_o, if2.result_o, if2.carry_o, if2.zero_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        int         sel;
        logic [7:0] a;
        logic [3:0] b;
        logic       dir;
        logic [1:0] mode;
        logic       fill;
        logic [7:0] res;
        logic       c;
        logic       z;
        int         lat;
    } vec_t;

    task automatic test_directed();
        vec_t v [8];
        logic [7:0] res;
        logic c, z;
        int lat;
        bit ok;
        v[0] = '{1, 8'h96, 4'd3, 1'b0, 2'b00, 1'b0, 8'hB0, 1'b0, 1'b0, 4};
        v[1] = '{1, 8'h96, 4'd3, 1'b0, 2'b00, 1'b1, 8'hB7, 1'b0, 1'b0, 4};
        v[2] = '{1, 8'h96, 4'd2, 1'b1, 2'b01, 1'b0, 8'hE5, 1'b1, 1'b0, 3};
        v[3] = '{1, 8'h96, 4'd3, 1'b0, 2'b10, 1'b0, 8'hB4, 1'b0, 1'b0, 4};
        v[4] = '{1, 8'h81, 4'd8, 1'b0, 2'b00, 1'b0, 8'h00, 1'b1, 1'b1, 9};
        v[5] = '{1, 8'h81, 4'd9, 1'b0, 2'b00, 1'b0, 8'h00, 1'b0, 1'b1, 10};
        v[6] = '{1, 8'h81, 4'd0, 1'b0, 2'b00, 1'b0, 8'h81, 1'b0, 1'b0, 1};
        v[7] = '{2, 8'h96, 4'd5, 1'b0, 2'b00, 1'b0, 8'hC0, 1'b0, 1'b0, 4};
        for (int i = 0; i < 8; i++) begin
            do_op(v[i].sel, v[i].a, v[i].b, v[i].dir, v[i].mode, v[i].fill, res, c, z, lat, ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL directed_%0d_timeout: no done_o, want done at clock %0d", i, v[i].lat);
            end
            checks++;
            if ({res, c, z} !== {v[i].res, v[i].c, v[i].z}) begin
                errors++;
                $display("FAIL directed_%0d_result: got res=%h c=%b z=%b, want res=%h c=%b z=%b",
                         i, res, c, z, v[i].res, v[i].c, v[i].z);
            end
            checks++;
            if (lat != v[i].lat) begin
                errors++;
                $display("FAIL directed_%0d_latency: got %0d, want %0d", i, lat, v[i].lat);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [8:0] exp_a, exp_b;
        int lat;
        int guard;
        exp_a = ref_shift(8'h96, 4'd5, 1'b1, 2'b00, 1'b1);
        exp_b = ref_shift(8'h3C, 4'd2, 1'b0, 2'b01, 1'b0);
        guard = 0;
        @(negedge clk);
        while (!if1.ready_o && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        a_r = 8'h96; b_r = 4'd5; dir_r = 1'b1; mode_r = 2'b00; fill_r = 1'b1;
        start1 = 1'b1;
        @(posedge clk); #1;
        // New request held on the inputs while the first one is still running.
        a_r = 8'h3C; b_r = 4'd2; dir_r = 1'b0; mode_r = 2'b01; fill_r = 1'b0;
        lat = 1;
        while (!if1.done_o && lat < 100) begin
            checks++;
            if (if1.ready_o !== 1'b0) begin
                errors++;
                $display("FAIL busy_ready: got ready=%b at clock %0d, want 0", if1.ready_o, lat);
            end
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if ({if1.carry_o, if1.result_o} !== exp_a || lat != 6) begin
            errors++;
            $display("FAIL busy_first: got res=%h c=%b lat=%0d, want res=%h c=%b lat=6",
                     if1.result_o, if1.carry_o, lat, exp_a[7:0], exp_a[8]);
        end
        @(posedge clk); #1;
        checks++;
        if (if1.ready_o !== 1'b1) begin
            errors++;
            $display("FAIL busy_idle_ready: got %b, want 1", if1.ready_o);
        end
        @(posedge clk); #1;
        start1 = 1'b0;
        lat = 1;
        while (!if1.done_o && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if ({if1.carry_o, if1.result_o} !== exp_b || lat != 3) begin
            errors++;
            $display("FAIL busy_second: got res=%h c=%b lat=%0d, want res=%h c=%b lat=3",
                     if1.result_o, if1.carry_o, lat, exp_b[7:0], exp_b[8]);
        end
    endtask

    task automatic test_reset_abort();
        logic [7:0] res;
        logic c, z;
        int lat;
        int dones;
        bit ok;
        @(negedge clk);
        a_r = 8'h5A; b_r = 4'd7; dir_r = 1'b0; mode_r = 2'b10; fill_r = 1'b0;
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({if1.ready_o, if1.done_o, if1.result_o, if1.carry_o, if1.zero_o} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL abort_state: rdy=%b done=%b res=%h c=%b z=%b, want 1 0 00 0 1",
                     if1.ready_o, if1.done_o, if1.result_o, if1.carry_o, if1.zero_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (if1.done_o) dones++;
        end
        checks++;
        if (dones != 0) begin
            errors++;
            $display("FAIL abort_no_done: got %0d done pulses, want 0", dones);
        end
        do_op(1, 8'h96, 4'd3, 1'b0, 2'b10, 1'b0, res, c, z, lat, ok);
        checks++;
        if (!ok || {res, c, z} !== {8'hB4, 1'b0, 1'b0} || lat != 4) begin
            errors++;
            $display("FAIL abort_recover: got ok=%b res=%h c=%b z=%b lat=%0d, want res=b4 c=0 z=0 lat=4",
                     ok, res, c, z, lat);
        end
    endtask

    task automatic test_random();
        logic [7:0] a, res;
        logic [3:0] b;
        logic [1:0] mode;
        logic dir, fill, c, z;
        logic [8:0] exp;
        int lat;
        bit ok;
        for (int i = 0; i < 60; i++) begin
            int sel;
            sel  = (i % 2) + 1;
            a    = 8'($urandom);
            b    = 4'($urandom_range(0, 11));
            dir  = 1'($urandom);
            mode = 2'($urandom);
            fill = 1'($urandom);
            exp  = ref_shift(a, b, dir, mode, fill);
            do_op(sel, a, b, dir, mode, fill, res, c, z, lat, ok);
            checks++;
            if (!ok || {c, res} !== exp || z !== (exp[7:0] == 8'h00) || lat != ref_lat(b, sel)) begin
                errors++;
                $display("FAIL random_%0d: dut%0d a=%h b=%0d dir=%b mode=%0d fill=%b got res=%h c=%b z=%b lat=%0d ok=%b, want res=%h c=%b lat=%0d",
                         i, sel, a, b, dir, mode, fill, res, c, z, lat, ok, exp[7:0], exp[8], ref_lat(b, sel));
            end
        end
    endtask

    initial begin
        @(posedge clk);
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_abort();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
